io_bus_sequencer: RTL and testbench

- Owns the shared backplane I/O bus (io_address / io_enable_n / io_data) and sequences single-word read and write cycles on it.
- Shares the bus between two requesters: the CPU console-I/O path and the periodic register scanner that refreshes the input/output register images.
- Sits between those requesters and the top-level tristate pad on io_data.
- Arbitration is 2-way round-robin; each bus cycle runs a fixed setup/strobe/hold/turnaround sequence.

---
 rtl/io_bus_pkg.sv | 24 ++
 rtl/io_bus_rr_arbiter.sv | 29 ++
 rtl/io_bus_sequencer.sv | 180 ++++++++++++++++++
 tb/tb_io_bus_sequencer.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/io_bus_pkg.sv
// rtl/io_bus_pkg.sv - shared types and constants for the backplane I/O bus sequencer
package io_bus_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        STROBE,
        HOLD,
        TURN
    } io_state_e;

    typedef enum logic {
        OWN_CPU  = 1'b0,
        OWN_SCAN = 1'b1
    } io_owner_e;

    // Bit positions within io_enable_n
    localparam int IO_RD = 0;
    localparam int IO_WR = 1;

    // Value returned by a read of an empty board slot
    localparam logic [7:0] IO_UNINSTALLED_RDATA = 8'hFF;

endpackage

// File: rtl/io_bus_rr_arbiter.sv
// rtl/io_bus_rr_arbiter.sv - combinational 2-way round-robin pick between CPU and scanner
//
// Ports:
//   cpu_req, scan_req : pending requests
//   owner             : last granted requester (register lives in the parent)
//   grant_valid       : at least one request pending
//   grant_owner       : requester that wins this cycle
module io_bus_rr_arbiter
    import io_bus_pkg::*;
(
    input  logic      cpu_req,
    input  logic      scan_req,
    input  io_owner_e owner,
    output logic      grant_valid,
    output io_owner_e grant_owner
);

    always_comb begin
        grant_valid = cpu_req | scan_req;
        grant_owner = OWN_CPU;
        if (cpu_req && scan_req) begin
            // Tie: hand the bus to whoever did not have it last
            grant_owner = (owner == OWN_CPU) ? OWN_SCAN : OWN_CPU;
        end else if (scan_req) begin
            grant_owner = OWN_SCAN;
        end
    end

endmodule

// File: rtl/io_bus_sequencer.sv
// rtl/io_bus_sequencer.sv - sequences single-word read/write cycles on the shared backplane I/O bus
//
// Ports:
//   Clk, Rst                     : clock, synchronous active-high reset
//   cpu_req/we/addr/wdata        : CPU console-I/O request (held until cpu_ack)
//   cpu_ack, cpu_rdata           : one-cycle completion pulse, read data (held until next CPU read)
//   scan_*                       : same interface for the register scanner
//   io_address, io_enable_n      : bus address, active-low strobes ([0] read, [1] write)
//   io_data_o, io_data_oe        : write data and output enable towards the tristate pad
//   io_data_i                    : read data from the pad
//   busy                         : sequencer not idle
//   owner                        : current/last grant (0 = CPU, 1 = scanner)
module io_bus_sequencer
    import io_bus_pkg::*;
#(
    parameter int BOARDS            = 16,
    parameter int INSTALLED_BOARDS  = 2,
    parameter int ADDR_WIDTH        = 4,
    parameter int DATA_WIDTH        = 8,
    parameter int STROBE_CYCLES     = 2,
    parameter int TURNAROUND_CYCLES = 1
) (
    input  logic                  Clk,
    input  logic                  Rst,
    input  logic                  cpu_req,
    input  logic                  cpu_we,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [DATA_WIDTH-1:0] cpu_wdata,
    output logic                  cpu_ack,
    output logic [DATA_WIDTH-1:0] cpu_rdata,
    input  logic                  scan_req,
    input  logic                  scan_we,
    input  logic [ADDR_WIDTH-1:0] scan_addr,
    input  logic [DATA_WIDTH-1:0] scan_wdata,
    output logic                  scan_ack,
    output logic [DATA_WIDTH-1:0] scan_rdata,
    output logic [ADDR_WIDTH-1:0] io_address,
    output logic [1:0]            io_enable_n,
    output logic [DATA_WIDTH-1:0] io_data_o,
    output logic                  io_data_oe,
    input  logic [DATA_WIDTH-1:0] io_data_i,
    output logic                  busy,
    output logic                  owner
);

    // One down-counter serves both STROBE and TURN; sized for the longer of the two
    localparam int CNT_MAX     = (STROBE_CYCLES > TURNAROUND_CYCLES) ? STROBE_CYCLES : TURNAROUND_CYCLES;
    localparam int CNT_W       = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int STROBE_LOAD = STROBE_CYCLES - 1;
    localparam int TURN_LOAD   = (TURNAROUND_CYCLES > 0) ? TURNAROUND_CYCLES - 1 : 0;

    io_state_e             state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  we_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    io_owner_e             owner_q;
    logic                  grant_valid;
    io_owner_e             grant_owner;
    logic                  installed;
    logic                  read_done;

    io_bus_rr_arbiter u_arb (
        .cpu_req     (cpu_req),
        .scan_req    (scan_req),
        .owner       (owner_q),
        .grant_valid (grant_valid),
        .grant_owner (grant_owner)
    );

    assign installed = (int'(addr_q) < INSTALLED_BOARDS);

    // Read data is sampled on the edge that closes the final strobe cycle
    assign read_done = (state_q == STROBE) && (cnt_q == '0) && !we_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (grant_valid) begin
                    state_d = SETUP;
                end
            end
            SETUP: begin
                // Empty slots skip the strobe entirely but still complete through HOLD
                if (installed) begin
                    state_d = STROBE;
                    cnt_d   = CNT_W'(STROBE_LOAD);
                end else begin
                    state_d = HOLD;
                end
            end
            STROBE: begin
                if (cnt_q == '0) begin
                    state_d = HOLD;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            HOLD: begin
                if (TURNAROUND_CYCLES == 0) begin
                    state_d = IDLE;
                end else begin
                    state_d = TURN;
                    cnt_d   = CNT_W'(TURN_LOAD);
                end
            end
            TURN: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            owner_q    <= OWN_SCAN;
            cpu_rdata  <= '0;
            scan_rdata <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (state_q == IDLE && grant_valid) begin
                owner_q <= grant_owner;
                if (grant_owner == OWN_CPU) begin
                    we_q    <= cpu_we;
                    addr_q  <= cpu_addr;
                    wdata_q <= cpu_wdata;
                end else begin
                    we_q    <= scan_we;
                    addr_q  <= scan_addr;
                    wdata_q <= scan_wdata;
                end
            end
            if (read_done) begin
                if (owner_q == OWN_CPU) begin
                    cpu_rdata <= io_data_i;
                end else begin
                    scan_rdata <= io_data_i;
                end
            end
            if (state_q == SETUP && !installed && !we_q) begin
                if (owner_q == OWN_CPU) begin
                    cpu_rdata <= DATA_WIDTH'(IO_UNINSTALLED_RDATA);
                end else begin
                    scan_rdata <= DATA_WIDTH'(IO_UNINSTALLED_RDATA);
                end
            end
        end
    end

    always_comb begin
        io_enable_n = 2'b11;
        if (state_q == STROBE) begin
            io_enable_n[we_q ? IO_WR : IO_RD] = 1'b0;
        end
    end

    assign io_address = addr_q;
    assign io_data_o  = wdata_q;
    assign io_data_oe = we_q && installed &&
                        ((state_q == SETUP) || (state_q == STROBE) || (state_q == HOLD));
    assign cpu_ack    = (state_q == HOLD) && (owner_q == OWN_CPU);
    assign scan_ack   = (state_q == HOLD) && (owner_q == OWN_SCAN);
    assign busy       = (state_q != IDLE);
    assign owner      = owner_q;

endmodule

// File: tb/tb_io_bus_sequencer.sv
// tb/tb_io_bus_sequencer.sv - self-checking bench for io_bus_sequencer
module tb_io_bus_sequencer;

    localparam int S    = 2;
    localparam int T    = 1;
    localparam int INST = 2;
    localparam int N    = 400;

    logic       Clk = 1'b0;
    always #5 Clk = ~Clk;

    logic       Rst;
    logic       cpu_req, cpu_we, scan_req, scan_we;
    logic [3:0] cpu_addr, scan_addr;
    logic [7:0] cpu_wdata, scan_wdata;
    logic       cpu_ack, scan_ack;
    logic [7:0] cpu_rdata, scan_rdata;
    logic [3:0] io_address;
    logic [1:0] io_enable_n;
    logic [7:0] io_data_o, io_data_i;
    logic       io_data_oe, busy, owner;

    logic       p_Rst;
    logic       p_cpu_req, p_cpu_we, p_scan_req, p_scan_we;
    logic [3:0] p_cpu_addr, p_scan_addr;
    logic [7:0] p_cpu_wdata, p_scan_wdata;
    logic       p_cpu_ack, p_scan_ack;
    logic [7:0] p_cpu_rdata, p_scan_rdata;
    logic [3:0] p_io_address;
    logic [1:0] p_io_enable_n;
    logic [7:0] p_io_data_o, p_io_data_i;
    logic       p_io_data_oe, p_busy, p_owner;
    bit         p_done = 1'b0;

    io_bus_sequencer #(
        .BOARDS(16), .INSTALLED_BOARDS(INST), .ADDR_WIDTH(4), .DATA_WIDTH(8),
        .STROBE_CYCLES(S), .TURNAROUND_CYCLES(T)
    ) dut (
        .Clk(Clk), .Rst(Rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
        .scan_req(scan_req), .scan_we(scan_we), .scan_addr(scan_addr), .scan_wdata(scan_wdata),
        .scan_ack(scan_ack), .scan_rdata(scan_rdata),
        .io_address(io_address), .io_enable_n(io_enable_n), .io_data_o(io_data_o),
        .io_data_oe(io_data_oe), .io_data_i(io_data_i), .busy(busy), .owner(owner)
    );

    io_bus_sequencer #(
        .BOARDS(16), .INSTALLED_BOARDS(INST), .ADDR_WIDTH(4), .DATA_WIDTH(8),
        .STROBE_CYCLES(1), .TURNAROUND_CYCLES(0)
    ) dut2 (
        .Clk(Clk), .Rst(p_Rst),
        .cpu_req(p_cpu_req), .cpu_we(p_cpu_we), .cpu_addr(p_cpu_addr), .cpu_wdata(p_cpu_wdata),
        .cpu_ack(p_cpu_ack), .cpu_rdata(p_cpu_rdata),
        .scan_req(p_scan_req), .scan_we(p_scan_we), .scan_addr(p_scan_addr), .scan_wdata(p_scan_wdata),
        .scan_ack(p_scan_ack), .scan_rdata(p_scan_rdata),
        .io_address(p_io_address), .io_enable_n(p_io_enable_n), .io_data_o(p_io_data_o),
        .io_data_oe(p_io_data_oe), .io_data_i(p_io_data_i), .busy(p_busy), .owner(p_owner)
    );

    int cyc = 0;
    always @(posedge Clk) cyc <= cyc + 1;

    // Expected per-cycle behaviour of the default instance
    logic [1:0] e_en[N];
    logic       e_oe[N], e_cack[N], e_sack[N], e_busy[N], e_own[N], chk[N];
    int         e_addr[N], e_do[N], e_crd[N], e_srd[N];

    int n_checks = 0;
    int n_pass   = 0;
    int cpu_ack_q[$], scan_ack_q[$], p_cpu_ack_q[$], p_scan_ack_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    endtask

    function automatic int last_of(input int q[$]);
        return (q.size() > 0) ? q[q.size()-1] : -1;
    endfunction

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic set_idle(input int a, input int b);
        for (int k = a; k <= b && k < N; k++) begin
            chk[k] = 1'b1; e_en[k] = 2'b11; e_oe[k] = 1'b0; e_cack[k] = 1'b0;
            e_sack[k] = 1'b0; e_busy[k] = 1'b0; e_addr[k] = -1; e_do[k] = -1;
            e_crd[k] = -1; e_srd[k] = -1;
        end
    endtask

    // A transaction granted in IDLE cycle t0: SETUP, STROBE x S, HOLD, TURN x T for an
    // installed slot; SETUP, HOLD, TURN x T for an empty one.
    task automatic plan(input int t0, input bit is_scan, input bit we, input int addr,
                        input int wdata, input int rd_in, output int nxt);
        bit inst;
        int p, ackk;
        inst = (addr < INST);
        p    = inst ? 3 + S + T : 3 + T;
        ackk = inst ? 2 + S : 2;
        for (int k = 1; k < p; k++) e_busy[t0+k] = 1'b1;
        for (int k = t0 + 1; k < N; k++) begin
            e_addr[k] = addr;
            e_own[k]  = is_scan;
        end
        if (inst) begin
            for (int k = 2; k <= 1 + S; k++) e_en[t0+k] = we ? 2'b01 : 2'b10;
            if (we) begin
                for (int k = 1; k <= 2 + S; k++) begin
                    e_oe[t0+k] = 1'b1;
                    e_do[t0+k] = wdata;
                end
            end
        end
        if (is_scan) e_sack[t0+ackk] = 1'b1;
        else         e_cack[t0+ackk] = 1'b1;
        if (!we) begin
            if (is_scan) e_srd[t0+ackk] = inst ? rd_in : 8'hFF;
            else         e_crd[t0+ackk] = inst ? rd_in : 8'hFF;
        end
        nxt = t0 + p;
    endtask

    task automatic txn(input bit is_scan, input bit we, input int addr, input int wdata,
                       input int rd_in, output int t0);
        int nxt, ackc;
        io_data_i = rd_in[7:0];
        if (is_scan) begin
            scan_we = we; scan_addr = addr[3:0]; scan_wdata = wdata[7:0]; scan_req = 1'b1;
        end else begin
            cpu_we = we; cpu_addr = addr[3:0]; cpu_wdata = wdata[7:0]; cpu_req = 1'b1;
        end
        t0 = cyc;
        plan(t0, is_scan, we, addr, wdata, rd_in, nxt);
        ackc = t0 + ((addr < INST) ? 2 + S : 2);
        while (cyc < ackc + 1) tick();
        cpu_req  = 1'b0;
        scan_req = 1'b0;
        while (cyc < nxt) tick();
    endtask

    // Compare process for the default instance
    always @(negedge Clk) begin
        int c;
        c = cyc;
        if (c < N && chk[c] === 1'b1) begin
            check("busy", busy, e_busy[c]);
            check("io_enable_n", io_enable_n, e_en[c]);
            check("io_data_oe", io_data_oe, e_oe[c]);
            check("cpu_ack", cpu_ack, e_cack[c]);
            check("scan_ack", scan_ack, e_sack[c]);
            check("owner", owner, e_own[c]);
            if (e_addr[c] >= 0) check("io_address", io_address, e_addr[c]);
            if (e_do[c] >= 0)   check("io_data_o", io_data_o, e_do[c]);
            if (e_crd[c] >= 0)  check("cpu_rdata", cpu_rdata, e_crd[c]);
            if (e_srd[c] >= 0)  check("scan_rdata", scan_rdata, e_srd[c]);
        end
        if (cpu_ack === 1'b1)  cpu_ack_q.push_back(c);
        if (scan_ack === 1'b1) scan_ack_q.push_back(c);
        if (p_cpu_ack === 1'b1)  p_cpu_ack_q.push_back(c);
        if (p_scan_ack === 1'b1) p_scan_ack_q.push_back(c);
        if (c > 0) begin
            assert (io_enable_n != 2'b00 && p_io_enable_n != 2'b00)
                else $error("both strobes low");
            if (!p_Rst) begin
                check("p_ack_exclusive", p_cpu_ack & p_scan_ack, 1'b0);
                check("p_enable_not_00", p_io_enable_n == 2'b00, 1'b0);
            end
        end
    end

    // Fast-parameter instance: STROBE_CYCLES = 1, TURNAROUND_CYCLES = 0, saturated from reset
    initial begin
        int c;
        p_Rst = 1'b1;
        p_cpu_req = 1'b1;  p_cpu_we = 1'b0;  p_cpu_addr = 4'd1;  p_cpu_wdata = 8'h00;
        p_scan_req = 1'b1; p_scan_we = 1'b1; p_scan_addr = 4'd0; p_scan_wdata = 8'h5C;
        p_io_data_i = 8'hA5;
        tick();
        tick();
        p_Rst = 1'b0;
        c = cyc;
        p_cpu_ack_q.delete();
        p_scan_ack_q.delete();
        while (cyc < c + 16) tick();
        p_cpu_req  = 1'b0;
        p_scan_req = 1'b0;
        while (cyc < c + 18) tick();
        check("p_cpu_ack_count", p_cpu_ack_q.size(), 2);
        check("p_scan_ack_count", p_scan_ack_q.size(), 2);
        if (p_cpu_ack_q.size() == 2 && p_scan_ack_q.size() == 2) begin
            check("p_cpu_ack_latency", p_cpu_ack_q[0] - c, 3);
            check("p_scan_ack_cycle", p_scan_ack_q[0] - c, 7);
            check("p_cpu_ack_period", p_cpu_ack_q[1] - p_cpu_ack_q[0], 8);
            check("p_scan_ack_cycle2", p_scan_ack_q[1] - c, 15);
        end
        check("p_cpu_rdata", p_cpu_rdata, 8'hA5);
        check("p_busy_idle", p_busy, 1'b0);
        p_done = 1'b1;
    end

    initial begin
        int t0, t1;
        for (int k = 0; k < N; k++) begin
            chk[k] = 1'b0;
            e_own[k] = 1'b1;
        end
        Rst = 1'b1;
        cpu_req = 1'b0;  cpu_we = 1'b0;  cpu_addr = '0;  cpu_wdata = '0;
        scan_req = 1'b0; scan_we = 1'b0; scan_addr = '0; scan_wdata = '0;
        io_data_i = '0;
        set_idle(1, N - 1);
        for (int k = 1; k < N; k++) e_addr[k] = 0;
        e_crd[1] = 0;
        e_srd[1] = 0;
        tick();
        tick();
        Rst = 1'b0;

        // CPU read of installed slot 1
        txn(1'b0, 1'b0, 1, 0, 8'h5A, t0);
        check("cpu_read_latency", last_of(cpu_ack_q) - t0, 4);
        check("cpu_read_rdata", cpu_rdata, 8'h5A);

        // Scanner write to slot 0
        txn(1'b1, 1'b1, 0, 8'hC3, 8'h00, t0);
        check("scan_write_latency", last_of(scan_ack_q) - t0, 4);

        // Reads of empty slots: 7, and the first empty slot 2
        txn(1'b0, 1'b0, 7, 0, 8'h11, t0);
        check("uninst_cpu_latency", last_of(cpu_ack_q) - t0, 2);
        check("uninst_cpu_rdata", cpu_rdata, 8'hFF);
        txn(1'b1, 1'b0, 2, 0, 8'h22, t0);
        check("uninst_scan_latency", last_of(scan_ack_q) - t0, 2);
        check("uninst_scan_rdata", scan_rdata, 8'hFF);

        // Scanner read of slot 1; CPU read data stays held
        txn(1'b1, 1'b0, 1, 0, 8'h77, t0);
        check("scan_read_rdata", scan_rdata, 8'h77);
        check("cpu_rdata_held", cpu_rdata, 8'hFF);

        // Write to top empty slot is discarded without driving the pad
        txn(1'b0, 1'b1, 15, 8'h42, 8'h00, t0);
        check("uninst_write_latency", last_of(cpu_ack_q) - t0, 2);

        // Reset in the first STROBE cycle of a CPU write
        cpu_we = 1'b1; cpu_addr = 4'd1; cpu_wdata = 8'h96; cpu_req = 1'b1;
        t0 = cyc;
        plan(t0, 1'b0, 1'b1, 1, 8'h96, 0, t1);
        tick();
        tick();
        Rst = 1'b1;
        cpu_req = 1'b0;
        tick();
        Rst = 1'b0;
        set_idle(t0 + 3, N - 1);
        for (int k = t0 + 3; k < N; k++) begin
            e_addr[k] = 0;
            e_own[k]  = 1'b1;
        end
        e_crd[t0+3] = 0;
        e_srd[t0+3] = 0;
        check("reset_owner", owner, 1'b1);
        check("reset_enable_n", io_enable_n, 2'b11);

        // Both requesters saturated: CPU wins the first tie, then strict alternation
        tick();
        t1 = cyc;
        io_data_i = 8'h3C;
        cpu_we = 1'b0;  cpu_addr = 4'd1;  cpu_req = 1'b1;
        scan_we = 1'b1; scan_addr = 4'd0; scan_wdata = 8'hE1; scan_req = 1'b1;
        cpu_ack_q.delete();
        scan_ack_q.delete();
        plan(t1,      1'b0, 1'b0, 1, 0,     8'h3C, t0);
        plan(t1 + 6,  1'b1, 1'b1, 0, 8'hE1, 0,     t0);
        plan(t1 + 12, 1'b0, 1'b0, 1, 0,     8'h3C, t0);
        plan(t1 + 18, 1'b1, 1'b1, 0, 8'hE1, 0,     t0);
        while (cyc < t1 + 23) tick();
        cpu_req  = 1'b0;
        scan_req = 1'b0;
        while (cyc < t1 + 25) tick();
        check("tie_cpu_ack_count", cpu_ack_q.size(), 2);
        check("tie_scan_ack_count", scan_ack_q.size(), 2);
        if (cpu_ack_q.size() == 2 && scan_ack_q.size() == 2) begin
            check("tie_first_cpu", cpu_ack_q[0] - t1, 4);
            check("tie_then_scan", scan_ack_q[0] - t1, 10);
            check("tie_cpu_again", cpu_ack_q[1] - t1, 16);
            check("tie_scan_again", scan_ack_q[1] - t1, 22);
        end
        check("tie_cpu_rdata", cpu_rdata, 8'h3C);

        for (int i = 0; i < 200 && !p_done; i++) tick();
        check("dut2_sequence_done", p_done, 1'b1);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
